// File: rtl/uart_tx_injector_pkg.sv
// Shared constants and types for the UART transmit injector.
package uart_tx_injector_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    st_idle,
    st_gap,
    st_start,
    st_data,
    st_parity,
    st_stop1,
    st_stop2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts a push when it is also being read.
  assign push_ready = !full || pop;
  assign do_push  = push_valid && push_ready;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_injector.sv
// UART transmitter fed by a byte FIFO, with programmable frame format and
// per-byte error injection (parity flip, shortened first stop bit).
module uart_tx_injector
  import uart_tx_injector_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              io_div,
  input  logic [1:0]                    io_parity,
  input  logic                          io_stop2,
  input  logic [3:0]                    io_gap,
  input  logic                          io_push_valid,
  output logic                          io_push_ready,
  input  logic [DATA_BITS-1:0]          io_push_data,
  input  logic                          io_push_inj_parity,
  input  logic                          io_push_inj_frame,
  output logic                          io_txd,
  output logic                          io_busy,
  output logic [$clog2(FIFO_DEPTH):0]   io_level,
  output logic [31:0]                   io_sent
);

  localparam int EW = DATA_BITS + 2;
  localparam int BW = $clog2(DATA_BITS);

  tx_state_t          state;
  logic [DIV_W-1:0]   cnt;
  logic [3:0]         gap_cnt;
  logic [BW-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic               par_bit;
  logic [DIV_W-1:0]   sh_div;
  logic [1:0]         sh_par;
  logic               sh_stop2;
  logic               sh_inj_frame;

  logic [EW-1:0]        head;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_inj_parity;
  logic                 head_inj_frame;
  logic                 fifo_empty;
  logic                 pop;
  logic                 frame_end;
  logic [1:0]           par_mode;
  logic                 par_calc;
  logic [DIV_W+1:0]     two_bits;
  logic [DIV_W+1:0]     stop_low;
  logic [DIV_W+1:0]     next_k;
  logic                 stop1_first;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (io_push_valid),
    .push_ready (io_push_ready),
    .push_data  ({io_push_inj_frame, io_push_inj_parity, io_push_data}),
    .pop        (pop),
    .pop_data   (head),
    .empty      (fifo_empty),
    .level      (io_level)
  );

  assign head_data       = head[DATA_BITS-1:0];
  assign head_inj_parity = head[DATA_BITS];
  assign head_inj_frame  = head[DATA_BITS+1];

  assign frame_end = (cnt == '0) &&
                     ((state == st_stop2) || (state == st_stop1 && !sh_stop2));
  // Popping straight out of the final stop cycle lets frames run back-to-back
  // without passing through an idle cycle.
  assign pop = !fifo_empty && ((state == st_idle) || frame_end);

  assign par_mode = (io_parity == PAR_EVEN || io_parity == PAR_ODD) ? io_parity : PAR_NONE;
  assign par_calc = (^head_data) ^ (io_parity == PAR_ODD) ^ head_inj_parity;

  // Shortened stop bit: low for floor(2*(div+1)/3) cycles. next_k is the index
  // within STOP1 of the cycle that the registered io_txd is about to present.
  assign two_bits    = ({2'b00, sh_div} + (DIV_W+2)'(1)) << 1;
  assign stop_low    = two_bits / (DIV_W+2)'(3);
  assign next_k      = {2'b00, sh_div} - {2'b00, cnt} + (DIV_W+2)'(1);
  assign stop1_first = !(sh_inj_frame && (stop_low != '0));

  assign io_busy = (state != st_idle) || !fifo_empty;

  // Frame FSM, bit timer, shifter and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= st_idle;
      io_txd       <= 1'b1;
      io_sent      <= '0;
      cnt          <= '0;
      gap_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      sh_div       <= '0;
      sh_par       <= PAR_NONE;
      sh_stop2     <= 1'b0;
      sh_inj_frame <= 1'b0;
    end else begin
      if (frame_end) io_sent <= io_sent + 32'd1;

      if (pop) begin
        sh_div       <= io_div;
        sh_par       <= par_mode;
        sh_stop2     <= io_stop2;
        sh_inj_frame <= head_inj_frame;
        shreg        <= head_data;
        par_bit      <= par_calc;
        cnt          <= io_div;
        bit_idx      <= '0;
        if (io_gap != 4'd0) begin
          state   <= st_gap;
          gap_cnt <= io_gap - 4'd1;
          io_txd  <= 1'b1;
        end else begin
          state   <= st_start;
          gap_cnt <= '0;
          io_txd  <= 1'b0;
        end
      end else if (state != st_idle && cnt != '0) begin
        cnt <= cnt - DIV_W'(1);
        if (state == st_stop1) io_txd <= !(sh_inj_frame && (next_k < stop_low));
      end else begin
        cnt <= sh_div;
        unique case (state)
          st_idle: io_txd <= 1'b1;
          st_gap: begin
            if (gap_cnt == 4'd0) begin
              state  <= st_start;
              io_txd <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          st_start: begin
            state  <= st_data;
            io_txd <= shreg[0];
            shreg  <= shreg >> 1;
          end
          st_data: begin
            if (bit_idx == BW'(DATA_BITS-1)) begin
              if (sh_par != PAR_NONE) begin
                state  <= st_parity;
                io_txd <= par_bit;
              end else begin
                state  <= st_stop1;
                io_txd <= stop1_first;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              io_txd  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          st_parity: begin
            state  <= st_stop1;
            io_txd <= stop1_first;
          end
          st_stop1: begin
            state  <= sh_stop2 ? st_stop2 : st_idle;
            io_txd <= 1'b1;
          end
          st_stop2: begin
            state  <= st_idle;
            io_txd <= 1'b1;
          end
          default: begin
            state  <= st_idle;
            io_txd <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_injector.sv
// Directed self-checking bench for uart_tx_injector.
module tb_uart_tx_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_div;
  logic [1:0]  io_parity;
  logic        io_stop2;
  logic [3:0]  io_gap;
  logic        io_push_valid;
  logic        io_push_ready;
  logic [7:0]  io_push_data;
  logic        io_push_inj_parity;
  logic        io_push_inj_frame;
  logic        io_txd;
  logic        io_busy;
  logic [4:0]  io_level;
  logic [31:0] io_sent;

  logic        push_valid5;
  logic        push_ready5;
  logic [4:0]  push_data5;
  logic        txd5;
  logic        busy5;
  logic [2:0]  level5;
  logic [31:0] sent5;

  int n_checks = 0;
  int n_err    = 0;
  int exp_sent = 0;

  always #5 clk = ~clk;

  uart_tx_injector #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .io_div(io_div), .io_parity(io_parity),
    .io_stop2(io_stop2), .io_gap(io_gap), .io_push_valid(io_push_valid),
    .io_push_ready(io_push_ready), .io_push_data(io_push_data),
    .io_push_inj_parity(io_push_inj_parity), .io_push_inj_frame(io_push_inj_frame),
    .io_txd(io_txd), .io_busy(io_busy), .io_level(io_level), .io_sent(io_sent)
  );

  uart_tx_injector #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
    .clk(clk), .reset(reset), .io_div(io_div), .io_parity(io_parity),
    .io_stop2(io_stop2), .io_gap(io_gap), .io_push_valid(push_valid5),
    .io_push_ready(push_ready5), .io_push_data(push_data5),
    .io_push_inj_parity(1'b0), .io_push_inj_frame(1'b0),
    .io_txd(txd5), .io_busy(busy5), .io_level(level5), .io_sent(sent5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic ip, input logic fi);
    io_push_valid      = 1'b1;
    io_push_data       = d;
    io_push_inj_parity = ip;
    io_push_inj_frame  = fi;
    tick();
    io_push_valid      = 1'b0;
    io_push_inj_parity = 1'b0;
    io_push_inj_frame  = 1'b0;
  endtask

  // seq[0] is the first bit-time on the line; each bit lasts div+1 cycles.
  task automatic check_frame(input string tag, input logic [15:0] seq, input int n,
                             input int div, input bit which);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= div; c++) begin
        check($sformatf("%s b%0d c%0d", tag, i, c),
              32'(which ? txd5 : io_txd), 32'(seq[i]));
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    logic [7:0] d;

    reset = 1'b1;
    io_div = 16'd2; io_parity = 2'b01; io_stop2 = 1'b0; io_gap = 4'd0;
    io_push_valid = 1'b0; io_push_data = '0;
    io_push_inj_parity = 1'b0; io_push_inj_frame = 1'b0;
    push_valid5 = 1'b0; push_data5 = '0;
    tick(); tick();
    check("rst txd",   32'(io_txd), 32'd1);
    check("rst ready", 32'(io_push_ready), 32'd1);
    check("rst busy",  32'(io_busy), 32'd0);
    check("rst level", 32'(io_level), 32'd0);
    check("rst sent",  io_sent, 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame: 0xA5, even parity (4 ones -> 0), one stop, div=2
    push(8'hA5, 1'b0, 1'b0);
    check("basic level1", 32'(io_level), 32'd1);
    check("basic busy",   32'(io_busy), 32'd1);
    tick();
    check("basic level0", 32'(io_level), 32'd0);
    check_frame("basic", 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 2, 1'b0);
    exp_sent++;
    check("basic sent", io_sent, 32'(exp_sent));
    check("basic idle txd", 32'(io_txd), 32'd1);
    check("basic idle busy", 32'(io_busy), 32'd0);

    // Odd parity, two stop bits, 0x00 -> parity 1
    io_parity = 2'b10; io_stop2 = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    tick();
    check_frame("odd2", 16'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0}), 12, 2, 1'b0);
    exp_sent++;
    check("odd2 sent", io_sent, 32'(exp_sent));

    // No parity, one stop
    io_parity = 2'b00; io_stop2 = 1'b0;
    push(8'h3C, 1'b0, 1'b0);
    tick();
    check_frame("nopar", 16'({1'b1, 8'h3C, 1'b0}), 10, 2, 1'b0);
    exp_sent++;
    check("nopar sent", io_sent, 32'(exp_sent));

    // Parity injection: even parity of 0x03 is 0, flipped to 1
    io_parity = 2'b01;
    push(8'h03, 1'b1, 1'b0);
    tick();
    check_frame("injpar", 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 2, 1'b0);
    exp_sent++;
    check("injpar sent", io_sent, 32'(exp_sent));

    // Framing injection, div=5: stop bit low 4 cycles then high 2
    io_div = 16'd5;
    push(8'h81, 1'b0, 1'b1);
    tick();
    check_frame("injfrm", 16'({1'b0, 8'h81, 1'b0}), 10, 5, 1'b0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("injfrm stop c%0d", c), 32'(io_txd), (c >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    exp_sent++;
    check("injfrm sent", io_sent, 32'(exp_sent));

    // Gap of 2 bit-times, div=1, no parity
    io_div = 16'd1; io_parity = 2'b00; io_gap = 4'd2;
    push(8'h55, 1'b0, 1'b0);
    tick();
    check_frame("gap", 16'({1'b1, 8'h55, 1'b0, 1'b1, 1'b1}), 12, 1, 1'b0);
    exp_sent++;
    check("gap sent", io_sent, 32'(exp_sent));

    // FIFO stress: one frame in flight, then 17 pushes into a 16-deep FIFO
    io_div = 16'd3; io_gap = 4'd0;
    push(8'hF0, 1'b0, 1'b0);
    tick();
    exp_sent++;
    for (int i = 0; i < 17; i++) begin
      io_push_valid = 1'b1;
      io_push_data  = 8'(8'h30 + i);
      check($sformatf("stress ready%0d", i), 32'(io_push_ready), (i < 16) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("stress level%0d", i), 32'(io_level), (i < 16) ? 32'(i + 1) : 32'd16);
    end
    io_push_data = 8'hEE;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      got = io_push_ready;
      tick();
    end
    io_push_valid = 1'b0;
    check("stress push on pop", 32'(got), 32'd1);
    check("stress level full", 32'(io_level), 32'd16);
    check("stress X sent", io_sent, 32'(exp_sent));
    for (int i = 0; i < 17; i++) begin
      d = (i < 16) ? 8'(8'h30 + i) : 8'hEE;
      check_frame($sformatf("stress f%0d", i), 16'({1'b1, d, 1'b0}), 10, 3, 1'b0);
      exp_sent++;
    end
    check("stress sent", io_sent, 32'(exp_sent));
    check("stress busy", 32'(io_busy), 32'd0);
    check("stress level0", 32'(io_level), 32'd0);

    // Reset during DATA bit 4 with one more byte waiting in the FIFO
    io_div = 16'd2; io_parity = 2'b01;
    push(8'hE0, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    check("rstmid bit4", 32'(io_txd), 32'd0);
    check("rstmid level", 32'(io_level), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid txd", 32'(io_txd), 32'd1);
    check("rstmid level0", 32'(io_level), 32'd0);
    check("rstmid sent", io_sent, 32'd0);
    check("rstmid busy", 32'(io_busy), 32'd0);
    tick();
    check("rstmid still idle", 32'(io_txd), 32'd1);
    push(8'h5A, 1'b0, 1'b0);
    tick();
    check_frame("postrst", 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 2, 1'b0);
    check("postrst sent", io_sent, 32'd1);

    // DATA_BITS=5 instance: 5'b10110 even parity -> 1, div=1
    io_div = 16'd1;
    check("d5 ready", 32'(push_ready5), 32'd1);
    push_valid5 = 1'b1;
    push_data5  = 5'b10110;
    tick();
    push_valid5 = 1'b0;
    check("d5 level", 32'(level5), 32'd1);
    tick();
    check_frame("d5", 16'({1'b1, 1'b1, 5'b10110, 1'b0}), 8, 1, 1'b1);
    check("d5 sent", sent5, 32'd1);
    check("d5 busy", 32'(busy5), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
